// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin encodings, values, FSM states and money width for vending blocks
package vend_pkg;

    localparam int MONEY_W = 16;

    typedef enum logic [1:0] {
        NICKEL  = 2'd0,
        DIME    = 2'd1,
        QUARTER = 2'd2,
        DOLLAR  = 2'd3
    } denom_t;

    localparam logic [MONEY_W-1:0] VAL_NICKEL  = 16'd5;
    localparam logic [MONEY_W-1:0] VAL_DIME    = 16'd10;
    localparam logic [MONEY_W-1:0] VAL_QUARTER = 16'd25;
    localparam logic [MONEY_W-1:0] VAL_DOLLAR  = 16'd100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] d);
        logic [MONEY_W-1:0] v;
        case (denom_t'(d))
            NICKEL:  v = VAL_NICKEL;
            DIME:    v = VAL_DIME;
            QUARTER: v = VAL_QUARTER;
            default: v = VAL_DOLLAR;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_coin_select.sv
// rtl/vend_coin_select.sv - picks the largest usable coin not exceeding the remaining change
module vend_coin_select
    import vend_pkg::*;
(
    input  logic [MONEY_W-1:0] remaining,
    input  logic [3:0]         hopper_empty,
    input  logic [3:0]         hopper_fault,
    output logic               found,
    output logic [1:0]         sel
);

    // Ascending scan: the last qualifying index is the largest denomination.
    always_comb begin
        found = 1'b0;
        sel   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!hopper_empty[i] && !hopper_fault[i] && (coin_value(2'(i)) <= remaining)) begin
                found = 1'b1;
                sel   = 2'(i);
            end
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// rtl/vend_change_dispenser.sv - pays change largest-coin-first over a hopper req/ack handshake
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [MONEY_W-1:0] change_amount,
    input  logic               change_valid,
    output logic               change_ready,
    input  logic [3:0]         hopper_empty,
    output logic               coin_req,
    output logic [1:0]         coin_sel,
    input  logic               coin_ack,
    output logic               done,
    output logic               short,
    output logic [MONEY_W-1:0] shortfall,
    output logic [7:0]         coins_issued,
    output logic [3:0]         hopper_fault
);

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [MONEY_W-1:0] remaining;
    logic [7:0]         timer;
    logic               pick_found;
    logic [1:0]         pick_sel;
    logic               timed_out;

    vend_coin_select u_select (
        .remaining    (remaining),
        .hopper_empty (hopper_empty),
        .hopper_fault (hopper_fault),
        .found        (pick_found),
        .sel          (pick_sel)
    );

    assign timed_out = (timer == TIMER_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        change_ready = 1'b0;
        coin_req     = 1'b0;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                change_ready = 1'b1;
                if (change_valid) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                state_nxt = pick_found ? ST_ISSUE : ST_DONE;
            end
            ST_ISSUE: begin
                coin_req = 1'b1;
                // Ack takes priority over a coincident timeout.
                if (coin_ack || timed_out) state_nxt = ST_SELECT;
            end
            default: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining    <= '0;
            timer        <= '0;
            coin_sel     <= 2'd0;
            short        <= 1'b0;
            shortfall    <= '0;
            coins_issued <= '0;
            hopper_fault <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (change_valid) begin
                        remaining    <= change_amount;
                        coins_issued <= '0;
                        short        <= 1'b0;
                        shortfall    <= '0;
                    end
                end
                ST_SELECT: begin
                    timer <= '0;
                    if (pick_found) begin
                        coin_sel <= pick_sel;
                    end else begin
                        // Result is published as DONE is entered so it is valid alongside done.
                        short     <= (remaining != '0);
                        shortfall <= remaining;
                    end
                end
                ST_ISSUE: begin
                    if (coin_ack) begin
                        remaining <= remaining - coin_value(coin_sel);
                        if (coins_issued != 8'hFF) coins_issued <= coins_issued + 8'd1;
                    end else if (timed_out) begin
                        hopper_fault[coin_sel] <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
